// File: rtl/sym_packer.sv
// sym_packer: packs SYM_W-bit symbols into SYMS_PER_WORD-symbol words and
// queues completed or flushed words in a small FIFO for a valid/ready sink.
module sym_packer #(
    parameter int SYM_W         = 2,
    parameter int SYMS_PER_WORD = 4,
    parameter int DEPTH         = 2,
    localparam int W            = SYM_W * SYMS_PER_WORD,
    localparam int LEN_W        = $clog2(SYMS_PER_WORD + 1)
) (
    input  logic             real_clk,
    input  logic             real_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SYM_W-1:0] in_sym,
    input  logic             flush,
    output logic             flush_ack,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_word,
    output logic [LEN_W-1:0] out_len
);

    localparam int CNT_W = $clog2(SYMS_PER_WORD);
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(SYMS_PER_WORD - 1);
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(SYMS_PER_WORD);

    logic [W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [W-1:0]     mem_word_q [DEPTH];
    logic [W-1:0]     mem_word_d [DEPTH];
    logic [LEN_W-1:0] mem_len_q [DEPTH];
    logic [LEN_W-1:0] mem_len_d [DEPTH];

    logic             full, empty, pop, can_push, last;
    logic             acc_en, full_push, push;
    logic [W-1:0]     push_word;
    logic [LEN_W-1:0] push_len;

    assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    // A pop frees the slot the same cycle, so a full FIFO can still take a push
    assign can_push  = ~full | pop;
    assign last      = (cnt_q == LAST);
    assign in_ready  = ~last | can_push;
    assign acc_en    = in_valid & in_ready;
    assign flush_ack = flush & can_push & ((cnt_q != '0) | acc_en);
    assign full_push = acc_en & last;
    assign push      = full_push | flush_ack;

    assign out_word = mem_word_q[rd_ptr_q[AW-1:0]];
    assign out_len  = mem_len_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        push_word = acc_q;
        if (acc_en) begin
            push_word[cnt_q*SYM_W +: SYM_W] = in_sym;
        end
        push_len = full_push ? FULL_LEN
                             : LEN_W'(cnt_q) + LEN_W'(acc_en);
    end

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        mem_word_d = mem_word_q;
        mem_len_d  = mem_len_q;
        wr_ptr_d  = wr_ptr_q + PW'(push);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        if (push) begin
            acc_d = '0;
            cnt_d = '0;
            mem_word_d[wr_ptr_q[AW-1:0]] = push_word;
            mem_len_d[wr_ptr_q[AW-1:0]]  = push_len;
        end else if (acc_en) begin
            acc_d = push_word;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge real_clk or posedge real_rst) begin
        if (real_rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_word_q <= '{default: '0};
            mem_len_q  <= '{default: '0};
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_word_q <= mem_word_d;
            mem_len_q  <= mem_len_d;
        end
    end

endmodule

// File: tb/tb_sym_packer.sv
// tb_sym_packer: directed and random stimulus for sym_packer, checked
// against a packing model feeding an expected-word queue.
module tb_sym_packer;

    localparam int N     = 4;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [7:0] w;
        logic [2:0] l;
    } exp_t;

    logic       real_clk = 1'b0;
    logic       real_rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_sym   = '0;
    logic       flush    = 1'b0;
    logic       flush_ack;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_word;
    logic [2:0] out_len;

    int total = 0;
    int bad   = 0;
    bit run   = 1'b0;

    exp_t       q[$];
    logic [1:0] mcnt;
    logic [7:0] macc;

    sym_packer #(.SYM_W(2), .SYMS_PER_WORD(N), .DEPTH(DEPTH)) dut (
        .real_clk (real_clk),
        .real_rst (real_rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sym   (in_sym),
        .flush    (flush),
        .flush_ack(flush_ack),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_word (out_word),
        .out_len  (out_len)
    );

    always #5 real_clk = ~real_clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        mcnt = '0;
        macc = '0;
    endtask

    // Model step: checks observed outputs, then advances to the next edge
    always @(negedge real_clk) begin
        if (run && !real_rst) begin
            logic       pop_m, can_m, rdy_m, acc_m, fa_m, full_m;
            logic [7:0] nacc;
            pop_m = (q.size() != 0) && out_ready;
            can_m = (q.size() < DEPTH) || pop_m;
            rdy_m = (mcnt != 2'(N - 1)) || can_m;
            acc_m = in_valid && rdy_m;
            fa_m  = flush && can_m && ((mcnt != 0) || acc_m);
            chk("in_ready", in_ready, rdy_m);
            chk("flush_ack", flush_ack, fa_m);
            chk("out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("out_word", out_word, q[0].w);
                chk("out_len", out_len, q[0].l);
            end
            chk("push_full", dut.push & dut.full & ~dut.pop, 1'b0);
            nacc = macc;
            if (acc_m) nacc[int'(mcnt)*2 +: 2] = in_sym;
            full_m = acc_m && (mcnt == 2'(N - 1));
            if (pop_m) void'(q.pop_front());
            if (full_m || fa_m) begin
                q.push_back('{w: nacc,
                              l: full_m ? 3'(N) : 3'(mcnt) + 3'(acc_m)});
                mcnt = '0;
                macc = '0;
            end else if (acc_m) begin
                mcnt = mcnt + 2'd1;
                macc = nacc;
            end
        end
    end

    task automatic tick();
        @(posedge real_clk);
        #1;
    endtask

    task automatic send(input logic [1:0] s);
        in_valid = 1'b1;
        in_sym   = s;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int n;
        model_clear();
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_word", out_word, 8'h00);
        chk("rst_out_len", out_len, 3'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_flush_ack", flush_ack, 1'b0);
        tick();
        real_rst = 1'b0;
        run = 1'b1;
        tick();

        // basic pack
        out_ready = 1'b1;
        send(2'd1); send(2'd2); send(2'd3); send(2'd0);
        @(negedge real_clk);
        chk("basic_valid", out_valid, 1'b1);
        chk("basic_word", out_word, 8'h39);
        chk("basic_len", out_len, 3'd4);
        tick();
        idle(2);

        // backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            in_sym = 2'($urandom);
            @(negedge real_clk);
            if (!in_ready) break;
            n++;
            tick();
        end
        chk("bp_accepts", n, 11);
        chk("bp_stall", in_ready, 1'b0);
        tick();
        out_ready = 1'b1;
        #1;
        chk("bp_pop_ready", in_ready, 1'b1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        idle(2);
        out_ready = 1'b1;
        idle(4);

        // partial flush
        send(2'd3); send(2'd3);
        flush = 1'b1;
        @(negedge real_clk);
        chk("pflush_ack", flush_ack, 1'b1);
        tick();
        flush = 1'b0;
        @(negedge real_clk);
        chk("pflush_word", out_word, 8'h0F);
        chk("pflush_len", out_len, 3'd2);
        tick();
        idle(2);

        // flush together with an accept, then an idle flush
        send(2'd1);
        in_valid = 1'b1;
        in_sym   = 2'd2;
        flush    = 1'b1;
        @(negedge real_clk);
        chk("aflush_ack", flush_ack, 1'b1);
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge real_clk);
        chk("aflush_word", out_word, 8'h09);
        chk("aflush_len", out_len, 3'd2);
        tick();
        idle(2);
        flush = 1'b1;
        @(negedge real_clk);
        chk("idle_flush_ack", flush_ack, 1'b0);
        tick();
        flush = 1'b0;
        @(negedge real_clk);
        chk("idle_flush_nopush", out_valid, 1'b0);
        tick();

        // async reset with two words queued and a partial word pending
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) send(2'(i + 1));
        #2;
        real_rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_out_word", out_word, 8'h00);
        chk("arst_in_ready", in_ready, 1'b1);
        model_clear();
        real_rst = 1'b0;
        out_ready = 1'b1;
        send(2'd2); send(2'd1); send(2'd0); send(2'd3);
        @(negedge real_clk);
        chk("arst_fresh_word", out_word, 8'hC6);
        chk("arst_fresh_len", out_len, 3'd4);
        tick();
        idle(2);

        // pointer wrap with sustained throughput
        for (int w = 0; w < 6; w++)
            for (int k = 0; k < N; k++) send(2'(w + k * (w + 1)));
        idle(3);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_sym    = 2'($urandom);
            out_ready = $urandom % 2;
            flush     = ($urandom % 6) == 0;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b1;
        idle(3);
        flush = 1'b0;
        idle(6);
        chk("drained", q.size(), 0);
        chk("drained_valid", out_valid, 1'b0);

        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
